// File: rtl/be_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// be_rr_arbiter_pkg
//   Shared definitions for the L1-to-L2 back-end round-robin arbiter.
//   Contents:
//     - bus slot widths (request slot, response slot)
//     - bit positions of each field inside one slot
//     - FSM state encoding (IDLE = 0, BUSY = 1)
//     - width of a master index (at least one bit, even for a single master)
//   Request slot layout, MSB to LSB:  {valid, addr, wdata, wstrb}
//   Response slot layout, MSB to LSB: {rdata, ready}
// ---------------------------------------------------------------------------
package be_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Response slot field positions (independent of the parameters).
    localparam int RESP_READY_POS = 0;
    localparam int RESP_RDATA_LSB = 1;

    // Request slot field positions.
    localparam int REQ_WSTRB_LSB = 0;

    function automatic int req_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    function automatic int resp_width(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int req_wdata_lsb(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int req_addr_lsb(input int data_w);
        return data_w + data_w / 8;
    endfunction

    function automatic int req_valid_pos(input int addr_w, input int data_w);
        return addr_w + data_w + data_w / 8;
    endfunction

    // Width of a master index; a single master still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/be_rr_arbiter_rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
//   Combinational rotating-priority picker. Searches the valid vector
//   starting at index ptr and moving upward (wrapping at N), and returns
//   the first set index.
//   Ports:
//     valid  [N-1:0]  request vector, bit i = master i
//     ptr    [W-1:0]  index that has highest priority (0..N-1)
//     winner [W-1:0]  chosen index (meaningful only when any = 1)
//     any             at least one bit of valid is set
// ---------------------------------------------------------------------------
module rr_priority_pick
    import be_rr_arbiter_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [W-1:0]   offset;
    logic [W:0]     sum;

    always_comb begin
        // Shifting a doubled copy rotates right by ptr without a modulo,
        // so bit 0 of rotated is master ptr.
        doubled = {valid, valid};
        rotated = N'(doubled >> ptr);

        any    = 1'b0;
        offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                any    = 1'b1;
                offset = W'(k);
            end
        end

        // Un-rotate: (ptr + offset) mod N with one conditional subtract,
        // which stays correct when N is not a power of two.
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (W + 1)'(N)) begin
            sum = sum - (W + 1)'(N);
        end
        winner = sum[W-1:0];
    end

endmodule

// File: rtl/be_rr_arbiter.sv
// ---------------------------------------------------------------------------
// be_rr_arbiter
//   Merges the native back-end buses of N L1 caches onto the single native
//   front-end port of the L2. One master owns the L2 port per transaction;
//   the most recently served master gets the lowest priority next time.
//
//   Handshake: a master raises valid with addr/wdata/wstrb and holds them
//   stable until it sees ready high for one cycle; that cycle completes the
//   transfer. If valid is still high in the following cycle it is a new
//   request. The L2 side follows the same rule: s_valid/fields are held
//   until the L2 returns ready.
//
//   Ports:
//     clk, rst                     clock, asynchronous active-low reset
//     m_req   [N*REQ_W-1:0]        packed master requests, master 0 in LSBs
//     m_resp  [N*RESP_W-1:0]       packed master responses
//     s_req   [REQ_W-1:0]          request to the L2 (one slot)
//     s_resp  [RESP_W-1:0]         response from the L2 (one slot)
//     grant   [GNT_W-1:0]          index of the current / last owner
//     busy                         high while a grant is held (FSM state)
// ---------------------------------------------------------------------------
module be_rr_arbiter
    import be_rr_arbiter_pkg::*;
#(
    parameter  int N_MASTERS = 4,
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 256,
    localparam int REQ_W     = req_width(ADDR_W, DATA_W),
    localparam int RESP_W    = resp_width(DATA_W),
    localparam int GNT_W     = idx_width(N_MASTERS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS*REQ_W-1:0]  m_req,
    output logic [N_MASTERS*RESP_W-1:0] m_resp,
    output logic [REQ_W-1:0]            s_req,
    input  logic [RESP_W-1:0]           s_resp,
    output logic [GNT_W-1:0]            grant,
    output logic                        busy
);

    localparam int VALID_POS = req_valid_pos(ADDR_W, DATA_W);

    arb_state_t           state;
    logic [GNT_W-1:0]     ptr;
    logic [GNT_W-1:0]     next_ptr;
    logic [GNT_W-1:0]     winner;
    logic                 any_valid;
    logic [N_MASTERS-1:0] m_valid;
    logic [REQ_W-1:0]     sel_req;
    logic                 sel_valid;
    logic                 s_ready;
    logic [DATA_W-1:0]    s_rdata;

    always_comb begin
        m_valid = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            m_valid[i] = m_req[i*REQ_W + VALID_POS];
        end
    end

    rr_priority_pick #(
        .N (N_MASTERS)
    ) u_pick (
        .valid  (m_valid),
        .ptr    (ptr),
        .winner (winner),
        .any    (any_valid)
    );

    // Request mux: a compare-per-slot mux never indexes past the last slot,
    // even for non-power-of-two master counts.
    always_comb begin
        sel_req = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant == GNT_W'(i)) begin
                sel_req = m_req[i*REQ_W +: REQ_W];
            end
        end
    end

    assign sel_valid = sel_req[VALID_POS];
    assign s_ready   = s_resp[RESP_READY_POS];
    assign s_rdata   = s_resp[RESP_RDATA_LSB +: DATA_W];
    assign busy      = (state == ST_BUSY);

    // Request fields pass straight through from the owner (they are held
    // stable by the master); the port is all zeros while idle or in reset.
    assign s_req = busy ? sel_req : '0;

    // Response demux: rdata to everyone, ready only to the owner and only
    // while it still asserts valid (a dropped request gets no ready).
    always_comb begin
        m_resp = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            m_resp[i*RESP_W + RESP_RDATA_LSB +: DATA_W] = busy ? s_rdata : '0;
            m_resp[i*RESP_W + RESP_READY_POS] =
                busy && sel_valid && s_ready && (grant == GNT_W'(i));
        end
    end

    assign next_ptr = (grant == GNT_W'(N_MASTERS - 1)) ? '0 : grant + GNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        grant <= winner;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!sel_valid) begin
                        // Owner withdrew before ready: drop it, keep priority.
                        state <= ST_IDLE;
                    end else if (s_ready) begin
                        ptr   <= next_ptr;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_be_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_be_rr_arbiter
//   Drives a 4-master and a 3-master arbiter (32-bit data) side by side.
//   A transaction-level reference model (owner / pointer / busy flag with
//   modulo arithmetic) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_be_rr_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int REQ_W  = 1 + AW + DW + SW;
    localparam int RESP_W = DW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic [4*REQ_W-1:0]  m_req4;
    logic [4*RESP_W-1:0] m_resp4;
    logic [REQ_W-1:0]    s_req4;
    logic [RESP_W-1:0]   s_resp4;
    logic [1:0]          grant4;
    logic                busy4;

    logic [3*REQ_W-1:0]  m_req3;
    logic [3*RESP_W-1:0] m_resp3;
    logic [REQ_W-1:0]    s_req3;
    logic [RESP_W-1:0]   s_resp3;
    logic [1:0]          grant3;
    logic                busy3;

    be_rr_arbiter #(.N_MASTERS(4), .ADDR_W(AW), .DATA_W(DW)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .m_req  (m_req4),
        .m_resp (m_resp4),
        .s_req  (s_req4),
        .s_resp (s_resp4),
        .grant  (grant4),
        .busy   (busy4)
    );

    be_rr_arbiter #(.N_MASTERS(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
        .clk    (clk),
        .rst    (rst),
        .m_req  (m_req3),
        .m_resp (m_resp3),
        .s_req  (s_req3),
        .s_resp (s_resp3),
        .grant  (grant3),
        .busy   (busy3)
    );

    // ---------------- stimulus state (index 0: N=4, index 1: N=3) ----------------
    logic          mv [2][4];
    logic [AW-1:0] ma [2][4];
    logic [DW-1:0] md [2][4];
    logic [SW-1:0] ms [2][4];
    logic          l2_ready [2];
    logic [DW-1:0] l2_rdata [2];

    // ---------------- reference model ----------------
    bit mdl_busy  [2];
    int mdl_owner [2];
    int mdl_ptr   [2];
    int served    [2];
    int ready_cnt [2][4];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                mv[d][i] = 1'b0;
                ma[d][i] = '0;
                md[d][i] = '0;
                ms[d][i] = '0;
            end
            l2_ready[d] = 1'b0;
            l2_rdata[d] = '0;
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < 4; i++)
            m_req4[i*REQ_W +: REQ_W] = {mv[0][i], ma[0][i], md[0][i], ms[0][i]};
        for (int i = 0; i < 3; i++)
            m_req3[i*REQ_W +: REQ_W] = {mv[1][i], ma[1][i], md[1][i], ms[1][i]};
        s_resp4 = {l2_rdata[0], l2_ready[0]};
        s_resp3 = {l2_rdata[1], l2_ready[1]};
    endtask

    task automatic new_req(input int d, input int i);
        mv[d][i] = 1'b1;
        ma[d][i] = $urandom;
        md[d][i] = $urandom;
        ms[d][i] = SW'($urandom_range(0, 15));
    endtask

    task automatic drive_random(input int d);
        int n;
        n = (d == 0) ? 4 : 3;
        for (int i = 0; i < n; i++) begin
            if (mv[d][i] && served[d] == i) begin
                if ($urandom_range(0, 3) == 0) new_req(d, i);
                else mv[d][i] = 1'b0;
            end else if (mv[d][i] && mdl_busy[d] && mdl_owner[d] == i
                         && $urandom_range(0, 39) == 0) begin
                mv[d][i] = 1'b0;
            end else if (!mv[d][i] && $urandom_range(0, 2) == 0) begin
                new_req(d, i);
            end
        end
        l2_ready[d] = ($urandom_range(0, 2) == 0);
        l2_rdata[d] = $urandom;
    endtask

    // ---------------- model ----------------
    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mdl_busy[d]  = 1'b0;
            mdl_owner[d] = 0;
            mdl_ptr[d]   = 0;
            served[d]    = -1;
        end
    endtask

    // Applies the rules of one clock edge to the model.
    task automatic advance(input int d);
        int n;
        int o;
        int c;
        bit found;
        n = (d == 0) ? 4 : 3;
        o = mdl_owner[d];
        served[d] = -1;
        found = 1'b0;
        if (!mdl_busy[d]) begin
            for (int k = 0; k < n; k++) begin
                c = (mdl_ptr[d] + k) % n;
                if (!found && mv[d][c]) begin
                    found        = 1'b1;
                    mdl_busy[d]  = 1'b1;
                    mdl_owner[d] = c;
                end
            end
        end else if (!mv[d][o]) begin
            mdl_busy[d] = 1'b0;
        end else if (l2_ready[d]) begin
            mdl_busy[d] = 1'b0;
            mdl_ptr[d]  = (o + 1) % n;
            served[d]   = o;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_dut(input int d);
        int n;
        int o;
        string pfx;
        logic [REQ_W-1:0]  sreq;
        logic [RESP_W-1:0] resp [4];
        logic [1:0]        g;
        logic              b;
        logic              exp_valid;
        logic              exp_rdy;
        n   = (d == 0) ? 4 : 3;
        pfx = (d == 0) ? "n4" : "n3";
        if (d == 0) begin
            sreq = s_req4; g = grant4; b = busy4;
            for (int i = 0; i < 4; i++) resp[i] = m_resp4[i*RESP_W +: RESP_W];
        end else begin
            sreq = s_req3; g = grant3; b = busy3;
            for (int i = 0; i < 3; i++) resp[i] = m_resp3[i*RESP_W +: RESP_W];
            resp[3] = '0;
        end
        o = mdl_owner[d];
        exp_valid = mdl_busy[d] && mv[d][o];
        check({pfx, "_busy"}, b, mdl_busy[d]);
        check({pfx, "_grant"}, g, o);
        check({pfx, "_s_valid"}, sreq[REQ_W-1], exp_valid);
        if (exp_valid)
            check({pfx, "_s_req"}, sreq, {1'b1, ma[d][o], md[d][o], ms[d][o]});
        if (!mdl_busy[d])
            check({pfx, "_s_req_idle"}, sreq, '0);
        for (int i = 0; i < n; i++) begin
            exp_rdy = exp_valid && l2_ready[d] && (i == o);
            check($sformatf("%s_ready%0d", pfx, i), resp[i][0], exp_rdy);
            check($sformatf("%s_rdata%0d", pfx, i), resp[i][RESP_W-1:1],
                  mdl_busy[d] ? l2_rdata[d] : '0);
            if (resp[i][0]) ready_cnt[d][i]++;
        end
    endtask

    task automatic settle();
        apply_inputs();
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    task automatic advance_clock();
        advance(0);
        advance(1);
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance_clock();
    endtask

    // Asserts reset with whatever the masters are driving, checks that all
    // outputs collapse at once, then releases reset on a falling edge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_s_req4", s_req4, '0);
        check("rst_m_resp4", m_resp4, '0);
        check("rst_grant4", grant4, 0);
        check("rst_busy4", busy4, 0);
        check("rst_s_req3", s_req3, '0);
        check("rst_m_resp3", m_resp3, '0);
        check("rst_grant3", grant3, 0);
        check("rst_busy3", busy3, 0);
        model_reset();
        clear_inputs();
        apply_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        clear_inputs();
        apply_inputs();
        model_reset();
        @(negedge clk);
        do_reset();

        // Single write from master 2, L2 ready on the third busy cycle.
        mv[0][2] = 1'b1; ma[0][2] = 32'h100; md[0][2] = 32'hDEADBEEF; ms[0][2] = 4'hF;
        step();
        settle();
        check("t1_grant", grant4, 2);
        check("t1_s_valid", s_req4[REQ_W-1], 1);
        advance_clock();
        step();
        l2_ready[0] = 1'b1;
        step();
        mv[0][2] = 1'b0; l2_ready[0] = 1'b0;
        step();
        step();
        check("t1_ready_m2", ready_cnt[0][2], 1);
        check("t1_ready_others", ready_cnt[0][0] + ready_cnt[0][1] + ready_cnt[0][3], 0);

        // Reset while master 0 holds the grant.
        mv[0][0] = 1'b1; ma[0][0] = 32'h200; md[0][0] = 32'h0BADF00D; ms[0][0] = 4'h3;
        step();
        settle();
        check("t1_busy_m0", busy4, 1);
        check("t1_grant_m0", grant4, 0);
        do_reset();

        // Fairness: everyone requests continuously, L2 answers at once.
        for (int i = 0; i < 4; i++) begin
            mv[0][i] = 1'b1; ma[0][i] = 32'h1000 + 32'(i); md[0][i] = 32'hC0DE0000 + 32'(i);
            ms[0][i] = 4'hF;
        end
        l2_ready[0] = 1'b1; l2_rdata[0] = 32'hA5A50000;
        for (int k = 0; k < 16; k++) begin
            check("fair_busy", busy4, k % 2);
            if (k % 2 == 1) check("fair_grant", grant4, (k / 2) % 4);
            step();
        end

        // Rotating priority: master 3 just served, 1 and 3 request.
        for (int i = 0; i < 4; i++) mv[0][i] = 1'b0;
        mv[0][1] = 1'b1; mv[0][3] = 1'b1; l2_ready[0] = 1'b0;
        step();
        check("rot_grant", grant4, 1);
        l2_ready[0] = 1'b1;
        step();
        mv[0][1] = 1'b0; mv[0][3] = 1'b0; l2_ready[0] = 1'b0;

        // Read return reaches master 0 in the same cycle.
        mv[0][0] = 1'b1; ma[0][0] = 32'h40; md[0][0] = '0; ms[0][0] = '0;
        step();
        l2_ready[0] = 1'b1; l2_rdata[0] = 32'h12345678;
        settle();
        check("rd_resp0", m_resp4[RESP_W-1:0], {32'h12345678, 1'b1});
        advance_clock();
        mv[0][0] = 1'b0; l2_ready[0] = 1'b0;

        // Abort: master 1 withdraws while granted.
        mv[0][1] = 1'b1; ma[0][1] = 32'h80;
        step();
        mv[0][1] = 1'b0;
        settle();
        check("abort_s_valid", s_req4[REQ_W-1], 0);
        check("abort_ready1", m_resp4[RESP_W], 0);
        advance_clock();
        check("abort_idle", busy4, 0);
        mv[0][0] = 1'b1; mv[0][1] = 1'b1;
        step();
        check("abort_ptr_kept", grant4, 1);
        l2_ready[0] = 1'b1;
        step();
        mv[0][1] = 1'b0; l2_ready[0] = 1'b0;

        // N=3 wrap-around.
        mv[1][2] = 1'b1; ma[1][2] = 32'h300;
        step();
        check("n3_grant2", grant3, 2);
        l2_ready[1] = 1'b1;
        step();
        l2_ready[1] = 1'b0;
        mv[1][0] = 1'b1; ma[1][0] = 32'h310;
        step();
        check("n3_wrap_grant", grant3, 0);
        l2_ready[1] = 1'b1;
        step();
        mv[1][0] = 1'b0; l2_ready[1] = 1'b0;
        step();
        check("n3_next_grant", grant3, 2);

        // Randomized traffic on both arbiters, with one reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            drive_random(0);
            drive_random(1);
            step();
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/be_rr_arbiter.md
# be_rr_arbiter

Round-robin arbiter that merges the native back-end buses of N L1 caches (data cache, instruction cache, Versat vector caches) into the single native front-end port of the L2 cache. It grants one master per transaction and holds that grant until the L2 returns `ready`. Arbitration is fair: the most recently served master gets the lowest priority. The block sits directly upstream of the L2 cache.

## Interface
- `N_MASTERS`, 4, number of requesting back-end buses (≥1)
- `ADDR_W`, 32, byte address width carried on the bus
- `DATA_W`, 256, data width (MIG bus width); strobe width is DATA_W/8
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `m_req`  in  N_MASTERS*REQ_W  packed master requests. Each slot is {valid, addr[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}. Master 0 is in the LSBs. REQ_W = 1+ADDR_W+DATA_W+DATA_W/8.
- `m_resp`  out  N_MASTERS*RESP_W  packed responses. Each slot is {rdata[DATA_W], ready}. RESP_W = DATA_W+1.
- `s_req`  out  REQ_W  request to the L2, same layout as one m_req slot
- `s_resp`  in  RESP_W  response from the L2
- `grant`  out  max(1,$clog2(N_MASTERS))  index of the current owner (debug)
- `busy`  out  1  high while a grant is held

## Operation
- Two-state FSM: IDLE and BUSY.
- **IDLE:**
  - s_valid = 0.
  - If any master valid is high, the winner is chosen by rotating priority starting at `ptr`: the first valid index from ptr upward, modulo N_MASTERS.
  - On the next edge: `grant` ← winner, state → BUSY.
  - If no master is valid, stay in IDLE.
- **BUSY:**
  - s_req = m_req[grant], driven combinationally from the live master inputs.
  - m_resp[grant].ready = s_ready. All other slots have ready = 0.
  - rdata = s_rdata is broadcast to every slot.
- **Completion:** s_ready = 1 while in BUSY. On the next edge: ptr ← (grant+1) mod N_MASTERS, state → IDLE.
- **Abort:** the granted master drops valid while in BUSY (protocol violation). s_valid follows it to 0. On the next edge: state → IDLE, ptr unchanged, and no ready is issued to any master.
- **Wrap-around:** ptr and grant wrap from N_MASTERS-1 to 0. This must be correct for N_MASTERS values that are not powers of 2.
- **N_MASTERS = 1:** the FSM is kept, grant is constant 0, and latency is unchanged.
- **Reset (asserted asynchronously):**
  - state = IDLE, grant = 0, ptr = 0, busy = 0.
  - s_valid = 0, all m_resp ready = 0.
  - s_req addr/wdata/wstrb = 0.
- **Reset mid-transaction:** the transaction is dropped with no ready to the master. The L2 sees s_valid fall immediately.

## Timing
- Request latency: a master valid first seen in cycle t appears as s_valid in cycle t+1, when the arbiter is idle.
- Response latency: zero added cycles. The ready from the L2 reaches the master in the same cycle.
- A one-cycle IDLE bubble follows every completion. Minimum occupancy is 2 + L2 latency cycles per transaction.
- A master's valid that is still high in the cycle after its ready is treated as a new request and arbitrated normally.
- Masters hold valid, addr, wdata and wstrb stable until they see ready. The arbiter does not register the request fields.
- Simultaneous valids in IDLE: only the rotating priority decides the winner. Request arrival order has no effect.

## Structure
- Shared include holds:
  - the REQ_W/RESP_W definitions;
  - the field position macros: valid, address, wdata, wstrb, rdata and ready, each indexed by slot;
  - the FSM state encoding (IDLE = 0, BUSY = 1).
- One sub-module, `rr_priority_pick`. It is combinational: it rotates the valid vector by ptr, takes the first set bit, and un-rotates the result. Outputs are `winner` and `any`.
- The top level contains the FSM, the grant and ptr registers, and the request mux and response demux.

## Test plan
- **Single request, reset mid-transaction:** N=4, DATA_W=32, reset released, master 2 writes addr 0x100, wdata 0xDEADBEEF, wstrb 0xF, L2 ready after 3 cycles.
  - grant = 2.
  - s_valid rises one cycle after m_valid.
  - m_resp[2].ready pulses exactly once. Other ready outputs stay 0.
  - Then reset is asserted with master 0 granted: all outputs are 0 immediately, and grant = 0 after reset.
- **Fairness:** all four masters hold valid continuously, L2 ready after 1 cycle. Grant order is 0,1,2,3,0,1,… with one IDLE cycle between grants.
- **Rotating priority:** after master 3 is served, masters 1 and 3 request together. Master 1 wins (ptr = 0, so the first set bit is index 1).
- **Read return:** master 0 reads addr 0x40 and the L2 returns rdata 0x12345678 with ready. m_resp[0] = {0x12345678, 1} in that same cycle.
- **Abort:** the granted master 1 drops valid in BUSY before the L2 gives ready. s_valid falls in the same cycle, the FSM returns to IDLE, no ready is issued, and ptr is unchanged.
- **N=3 wrap-around:** masters 2 and 0 request after master 2 is served. Master 0 wins, and ptr never reaches 3.
